// File: rtl/rdma_flow_ctrl_pkg.sv
// Shared types for the RDMA request flow controller: queue-ID packing, table entry, FSM states.
package rdma_flow_ctrl_pkg;

    localparam int unsigned RDMA_N_WR_OUTSTANDING = 32;
    localparam int unsigned N_REGIONS_BITS        = 4;
    localparam int unsigned PID_BITS              = 6;
    localparam int unsigned DEF_QID_BITS          = 1 + N_REGIONS_BITS + PID_BITS;
    localparam int unsigned DEF_OST_BITS          = $clog2(RDMA_N_WR_OUTSTANDING);

    typedef struct packed {
        logic [DEF_OST_BITS-1:0] head;
        logic [DEF_OST_BITS:0]   cnt;
    } flow_entry_t;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StLupWait,
        StAckLup,
        StReqLup,
        StFlush
    } fc_state_e;

    // Callers build s_req_qid and s_ack_qid through this so both paths index the same entry.
    function automatic logic [DEF_QID_BITS-1:0] qid_pack(input logic                      is_rd,
                                                         input logic [N_REGIONS_BITS-1:0] vfid,
                                                         input logic [PID_BITS-1:0]       pid);
        return {is_rd, vfid, pid};
    endfunction

endpackage

// File: rtl/rdma_flow_ctrl_queue.sv
// Small circular output buffer with a full flag; combinational head-of-queue read.
module rdma_flow_ctrl_queue #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    output logic             full_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    localparam int unsigned PtrBits = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrBits:0] DepthW = (PtrBits+1)'(Depth);

    logic [Width-1:0]   mem_q [Depth];
    logic [PtrBits-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrBits:0]   count_q;
    logic               push_ok, pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == DepthW);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop     = valid_o && ready_i;

    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PtrBits+1)'(push_ok) - (PtrBits+1)'(pop);
        end
    end

endmodule

// File: rtl/rdma_flow_ctrl.sv
// Per-queue outstanding-request window with sequence stamping, ACK credit return,
// queue flush and underflow reporting. One table operation in flight at a time.
module rdma_flow_ctrl
    import rdma_flow_ctrl_pkg::*;
#(
    parameter int unsigned QID_BITS  = DEF_QID_BITS,
    parameter int unsigned N_OST     = RDMA_N_WR_OUTSTANDING,
    parameter int unsigned DATA_BITS = 128,
    parameter int unsigned ACK_BITS  = 64,
    localparam int unsigned OST_BITS = $clog2(N_OST)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [OST_BITS:0]    cfg_limit,
    output logic                 init_done,
    input  logic                 s_req_valid,
    output logic                 s_req_ready,
    input  logic [QID_BITS-1:0]  s_req_qid,
    input  logic [DATA_BITS-1:0] s_req_data,
    output logic                 m_req_valid,
    input  logic                 m_req_ready,
    output logic [DATA_BITS-1:0] m_req_data,
    output logic [OST_BITS-1:0]  m_req_seq,
    input  logic                 s_ack_valid,
    output logic                 s_ack_ready,
    input  logic [QID_BITS-1:0]  s_ack_qid,
    input  logic                 s_ack_last,
    input  logic [ACK_BITS-1:0]  s_ack_data,
    output logic                 m_ack_valid,
    input  logic                 m_ack_ready,
    output logic [ACK_BITS-1:0]  m_ack_data,
    input  logic                 flush_valid,
    output logic                 flush_ready,
    input  logic [QID_BITS-1:0]  flush_qid,
    output logic                 err_uflow,
    output logic [QID_BITS-1:0]  err_qid
);

    localparam int unsigned DEPTH = 2 ** QID_BITS;
    localparam logic [OST_BITS:0] N_OST_W = (OST_BITS+1)'(N_OST);

    typedef struct packed {
        logic [OST_BITS-1:0] head;
        logic [OST_BITS:0]   cnt;
    } entry_t;

    fc_state_e           state_q, state_d;
    logic [QID_BITS-1:0] init_addr_q, init_addr_d;
    logic [QID_BITS-1:0] op_qid_q, op_qid_d;
    logic                op_ack_q, op_ack_d;
    logic                init_done_q, init_done_d;
    logic                err_uflow_q, err_uflow_d;
    logic [QID_BITS-1:0] err_qid_q, err_qid_d;

    logic                tbl_en, tbl_we;
    logic [QID_BITS-1:0] tbl_addr;
    entry_t              tbl_wdata, tbl_rdata;
    entry_t              tbl_mem [DEPTH];

    logic                          req_push, req_full, ack_push, ack_full;
    logic [DATA_BITS+OST_BITS-1:0] req_q_data;
    logic [OST_BITS:0]             eff_limit;

    assign eff_limit = (cfg_limit > N_OST_W) ? N_OST_W : cfg_limit;

    // Single-port table; read data holds while the port is idle, which LUP_WAIT relies on.
    always_ff @(posedge aclk) begin
        if (tbl_en) begin
            if (tbl_we) tbl_mem[tbl_addr] <= tbl_wdata;
            else        tbl_rdata         <= tbl_mem[tbl_addr];
        end
    end

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        op_qid_d    = op_qid_q;
        op_ack_d    = op_ack_q;
        init_done_d = init_done_q;
        err_uflow_d = 1'b0;
        err_qid_d   = err_qid_q;
        tbl_en      = 1'b0;
        tbl_we      = 1'b0;
        tbl_addr    = op_qid_q;
        tbl_wdata   = '0;
        s_req_ready = 1'b0;
        s_ack_ready = 1'b0;
        flush_ready = 1'b0;
        req_push    = 1'b0;
        ack_push    = 1'b0;
        unique case (state_q)
            StInit: begin
                tbl_en      = 1'b1;
                tbl_we      = 1'b1;
                tbl_addr    = init_addr_q;
                init_addr_d = init_addr_q + 1'b1;
                if (init_addr_q == {QID_BITS{1'b1}}) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end
            end
            StIdle: begin
                if (s_ack_valid && !ack_full) begin
                    s_ack_ready = 1'b1;
                    ack_push    = s_ack_last;
                    tbl_en      = 1'b1;
                    tbl_addr    = s_ack_qid;
                    op_qid_d    = s_ack_qid;
                    op_ack_d    = 1'b1;
                    state_d     = StLupWait;
                end else if (flush_valid) begin
                    flush_ready = 1'b1;
                    op_qid_d    = flush_qid;
                    state_d     = StFlush;
                end else if (s_req_valid && !req_full) begin
                    tbl_en   = 1'b1;
                    tbl_addr = s_req_qid;
                    op_qid_d = s_req_qid;
                    op_ack_d = 1'b0;
                    state_d  = StLupWait;
                end
            end
            StLupWait: begin
                state_d = op_ack_q ? StAckLup : StReqLup;
            end
            StAckLup: begin
                state_d = StIdle;
                if (tbl_rdata.cnt != '0) begin
                    tbl_en         = 1'b1;
                    tbl_we         = 1'b1;
                    tbl_wdata.head = tbl_rdata.head;
                    tbl_wdata.cnt  = tbl_rdata.cnt - 1'b1;
                end else begin
                    err_uflow_d = 1'b1;
                    err_qid_d   = op_qid_q;
                end
            end
            StReqLup: begin
                state_d = StIdle;
                if (tbl_rdata.cnt < eff_limit) begin
                    s_req_ready = 1'b1;
                    // A withdrawn request must not consume a credit.
                    if (s_req_valid) begin
                        req_push       = 1'b1;
                        tbl_en         = 1'b1;
                        tbl_we         = 1'b1;
                        tbl_wdata.head = tbl_rdata.head + 1'b1;
                        tbl_wdata.cnt  = tbl_rdata.cnt + 1'b1;
                    end
                end
            end
            StFlush: begin
                tbl_en  = 1'b1;
                tbl_we  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= StInit;
            init_addr_q <= '0;
            op_qid_q    <= '0;
            op_ack_q    <= 1'b0;
            init_done_q <= 1'b0;
            err_uflow_q <= 1'b0;
            err_qid_q   <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            op_qid_q    <= op_qid_d;
            op_ack_q    <= op_ack_d;
            init_done_q <= init_done_d;
            err_uflow_q <= err_uflow_d;
            err_qid_q   <= err_qid_d;
        end
    end

    assign init_done = init_done_q;
    assign err_uflow = err_uflow_q;
    assign err_qid   = err_qid_q;

    rdma_flow_ctrl_queue #(
        .Width(DATA_BITS + OST_BITS),
        .Depth(N_OST)
    ) u_req_queue (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .push_i     (req_push),
        .push_data_i({s_req_data, tbl_rdata.head}),
        .full_o     (req_full),
        .valid_o    (m_req_valid),
        .ready_i    (m_req_ready),
        .data_o     (req_q_data)
    );

    assign m_req_data = req_q_data[DATA_BITS+OST_BITS-1:OST_BITS];
    assign m_req_seq  = req_q_data[OST_BITS-1:0];

    rdma_flow_ctrl_queue #(
        .Width(ACK_BITS),
        .Depth(N_OST)
    ) u_ack_queue (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .push_i     (ack_push),
        .push_data_i(s_ack_data),
        .full_o     (ack_full),
        .valid_o    (m_ack_valid),
        .ready_i    (m_ack_ready),
        .data_o     (m_ack_data)
    );

endmodule

// File: tb/tb_rdma_flow_ctrl.sv
// Scoreboard bench for rdma_flow_ctrl: per-queue credit/sequence model, decoupled output monitors.
module tb_rdma_flow_ctrl;

    localparam int unsigned QID_BITS  = 3;
    localparam int unsigned N_OST     = 4;
    localparam int unsigned OST_BITS  = 2;
    localparam int unsigned DATA_BITS = 128;
    localparam int unsigned ACK_BITS  = 64;

    logic                 aclk, aresetn;
    logic [OST_BITS:0]    cfg_limit;
    logic                 init_done;
    logic                 s_req_valid, s_req_ready;
    logic [QID_BITS-1:0]  s_req_qid;
    logic [DATA_BITS-1:0] s_req_data;
    logic                 m_req_valid, m_req_ready;
    logic [DATA_BITS-1:0] m_req_data;
    logic [OST_BITS-1:0]  m_req_seq;
    logic                 s_ack_valid, s_ack_ready;
    logic [QID_BITS-1:0]  s_ack_qid;
    logic                 s_ack_last;
    logic [ACK_BITS-1:0]  s_ack_data;
    logic                 m_ack_valid, m_ack_ready;
    logic [ACK_BITS-1:0]  m_ack_data;
    logic                 flush_valid, flush_ready;
    logic [QID_BITS-1:0]  flush_qid;
    logic                 err_uflow;
    logic [QID_BITS-1:0]  err_qid;

    rdma_flow_ctrl #(
        .QID_BITS (QID_BITS),
        .N_OST    (N_OST),
        .DATA_BITS(DATA_BITS),
        .ACK_BITS (ACK_BITS)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .cfg_limit  (cfg_limit),
        .init_done  (init_done),
        .s_req_valid(s_req_valid),
        .s_req_ready(s_req_ready),
        .s_req_qid  (s_req_qid),
        .s_req_data (s_req_data),
        .m_req_valid(m_req_valid),
        .m_req_ready(m_req_ready),
        .m_req_data (m_req_data),
        .m_req_seq  (m_req_seq),
        .s_ack_valid(s_ack_valid),
        .s_ack_ready(s_ack_ready),
        .s_ack_qid  (s_ack_qid),
        .s_ack_last (s_ack_last),
        .s_ack_data (s_ack_data),
        .m_ack_valid(m_ack_valid),
        .m_ack_ready(m_ack_ready),
        .m_ack_data (m_ack_data),
        .flush_valid(flush_valid),
        .flush_ready(flush_ready),
        .flush_qid  (flush_qid),
        .err_uflow  (err_uflow),
        .err_qid    (err_qid)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model: per queue, next sequence number and credits in use.
    int m_head [8];
    int m_cnt  [8];

    typedef struct {
        logic [DATA_BITS-1:0] data;
        int                   seq;
    } req_exp_t;

    req_exp_t             exp_req   [$];
    logic [ACK_BITS-1:0]  exp_ack   [$];
    int                   exp_uflow [$];

    bit mon_en   = 1'b0;
    int req_mode = 1;  // 0 stall, 1 always ready, 2 random
    int ack_mode = 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    always @(posedge aclk) begin
        #1;
        case (req_mode)
            0:       m_req_ready = 1'b0;
            1:       m_req_ready = 1'b1;
            default: m_req_ready = 1'($urandom_range(0, 1));
        endcase
        case (ack_mode)
            0:       m_ack_ready = 1'b0;
            1:       m_ack_ready = 1'b1;
            default: m_ack_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge aclk) begin
        req_exp_t e;
        logic [ACK_BITS-1:0] a;
        int q;
        if (mon_en) begin
            if (m_req_valid && m_req_ready) begin
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected: got seq %0d, expected no output", m_req_seq);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_data", 128'(m_req_data), 128'(e.data));
                    chk("req_seq", 128'(m_req_seq), 128'(e.seq));
                end
            end
            if (m_ack_valid && m_ack_ready) begin
                if (exp_ack.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ack_unexpected: got %0h, expected no output", m_ack_data);
                end else begin
                    a = exp_ack.pop_front();
                    chk("ack_data", 128'(m_ack_data), 128'(a));
                end
            end
            if (err_uflow) begin
                if (exp_uflow.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL uflow_unexpected: got qid %0d, expected no pulse", err_qid);
                end else begin
                    q = exp_uflow.pop_front();
                    chk("uflow_qid", 128'(err_qid), 128'(q));
                end
            end
        end
    end

    function automatic int eff_limit();
        int l = int'(cfg_limit);
        return (l > int'(N_OST)) ? int'(N_OST) : l;
    endfunction

    task automatic do_req(input int q, input bit force_block);
        logic [DATA_BITS-1:0] d;
        bit admit, hs;
        int budget;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        admit = !force_block && (m_cnt[q] < eff_limit());
        if (admit) begin
            exp_req.push_back('{data: d, seq: m_head[q]});
            m_head[q] = (m_head[q] + 1) % int'(N_OST);
            m_cnt[q]++;
        end
        s_req_valid = 1'b1;
        s_req_qid   = 3'(q);
        s_req_data  = d;
        hs = 1'b0;
        budget = admit ? 80 : 15;
        for (int i = 0; i < budget && !hs; i++) begin
            @(negedge aclk);
            if (s_req_ready) hs = 1'b1;
            tick();
        end
        s_req_valid = 1'b0;
        chk($sformatf("req_handshake q%0d", q), 128'(hs), 128'(admit));
    endtask

    task automatic do_ack(input int q, input bit last);
        logic [ACK_BITS-1:0] d;
        bit hs;
        d = {$urandom(), $urandom()};
        if (m_cnt[q] > 0) m_cnt[q]--;
        else              exp_uflow.push_back(q);
        if (last) exp_ack.push_back(d);
        s_ack_valid = 1'b1;
        s_ack_qid   = 3'(q);
        s_ack_last  = last;
        s_ack_data  = d;
        hs = 1'b0;
        for (int i = 0; i < 80 && !hs; i++) begin
            @(negedge aclk);
            if (s_ack_ready) hs = 1'b1;
            tick();
        end
        s_ack_valid = 1'b0;
        chk("ack_handshake", 128'(hs), 128'(1));
    endtask

    task automatic do_flush(input int q);
        bit hs;
        m_cnt[q]  = 0;
        m_head[q] = 0;
        flush_valid = 1'b1;
        flush_qid   = 3'(q);
        hs = 1'b0;
        for (int i = 0; i < 80 && !hs; i++) begin
            @(negedge aclk);
            if (flush_ready) hs = 1'b1;
            tick();
        end
        flush_valid = 1'b0;
        chk("flush_handshake", 128'(hs), 128'(1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && (exp_req.size() + exp_ack.size() + exp_uflow.size()) != 0; i++)
            tick();
    endtask

    initial begin
        int n;
        bit rdy_seen;
        int ack_t, fl_t, rq_t;
        logic [DATA_BITS-1:0] pd;
        logic [ACK_BITS-1:0]  pa;

        for (int i = 0; i < 8; i++) begin
            m_head[i] = 0;
            m_cnt[i]  = 0;
        end
        aresetn = 1'b0;
        cfg_limit = 3'd4;
        s_req_valid = 1'b0; s_req_qid = '0; s_req_data = '0;
        s_ack_valid = 1'b0; s_ack_qid = '0; s_ack_last = 1'b0; s_ack_data = '0;
        flush_valid = 1'b0; flush_qid = '0;

        // Reset values
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_init_done", 128'(init_done), 128'(0));
        chk("rst_err_uflow", 128'(err_uflow), 128'(0));
        chk("rst_err_qid", 128'(err_qid), 128'(0));
        chk("rst_m_req_valid", 128'(m_req_valid), 128'(0));
        chk("rst_m_ack_valid", 128'(m_ack_valid), 128'(0));
        chk("rst_readies", 128'({s_req_ready, s_ack_ready, flush_ready}), 128'(0));

        tick();
        aresetn = 1'b1;
        mon_en  = 1'b1;
        n = 0;
        rdy_seen = 1'b0;
        while (n < 20) begin
            @(negedge aclk);
            if (init_done) n = n + 100;
            else begin
                rdy_seen |= s_req_ready | s_ack_ready | flush_ready;
                n++;
            end
        end
        chk("init_latency", 128'(n - 100), 128'(8));
        chk("no_ready_during_init", 128'(rdy_seen), 128'(0));
        tick();

        // Window of 4 on qid 2, fifth waits for a credit and wraps to seq 0
        cfg_limit = 3'd4;
        for (int i = 0; i < 5; i++) do_req(2, 1'b0);
        do_ack(2, 1'b0);
        do_req(2, 1'b0);

        // Window of 2 on qids 1 and 5, then raised to 3
        cfg_limit = 3'd2;
        for (int i = 0; i < 6; i++) do_req((i % 2) ? 5 : 1, 1'b0);
        cfg_limit = 3'd3;
        do_req(1, 1'b0);
        do_req(5, 1'b0);
        do_req(1, 1'b0);

        // Underflow on an untouched queue; entry must remain zero
        do_ack(3, 1'b1);
        do_req(3, 1'b0);
        wait_drain();

        // ACK, flush and request presented together
        cfg_limit = 3'd4;
        repeat (6) tick();
        pa = {$urandom(), $urandom()};
        pd = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (m_cnt[2] > 0) m_cnt[2]--;
        else              exp_uflow.push_back(2);
        exp_ack.push_back(pa);
        m_cnt[2] = 0;
        m_head[2] = 0;
        exp_req.push_back('{data: pd, seq: 0});
        m_head[2] = 1;
        m_cnt[2]  = 1;
        s_ack_valid = 1'b1; s_ack_qid = 3'd2; s_ack_last = 1'b1; s_ack_data = pa;
        flush_valid = 1'b1; flush_qid = 3'd2;
        s_req_valid = 1'b1; s_req_qid = 3'd2; s_req_data = pd;
        ack_t = -1; fl_t = -1; rq_t = -1;
        for (int c = 0; c < 60 && (ack_t < 0 || fl_t < 0 || rq_t < 0); c++) begin
            @(negedge aclk);
            if (s_ack_valid && s_ack_ready) ack_t = c;
            if (flush_valid && flush_ready) fl_t = c;
            if (s_req_valid && s_req_ready) rq_t = c;
            tick();
            if (ack_t >= 0) s_ack_valid = 1'b0;
            if (fl_t >= 0)  flush_valid = 1'b0;
            if (rq_t >= 0)  s_req_valid = 1'b0;
        end
        s_ack_valid = 1'b0; flush_valid = 1'b0; s_req_valid = 1'b0;
        chk("prio_ack_cycle", 128'(ack_t), 128'(0));
        chk("prio_flush_cycle", 128'(fl_t), 128'(3));
        chk("prio_req_cycle", 128'(rq_t), 128'(7));
        wait_drain();

        // Output request queue full blocks admission
        req_mode = 0;
        for (int i = 0; i < 4; i++) do_req(6, 1'b0);
        do_req(7, 1'b1);
        req_mode = 1;
        wait_drain();
        chk("full_drain_done", 128'(exp_req.size()), 128'(0));
        do_req(7, 1'b0);

        // Randomised traffic with back-pressure on both outputs
        req_mode = 2;
        ack_mode = 2;
        for (int k = 0; k < 250; k++) begin
            int r, q;
            r = $urandom_range(0, 99);
            q = $urandom_range(0, 3);
            if (r < 8)       cfg_limit = 3'($urandom_range(0, 7));
            else if (r < 13) do_flush(q);
            else if (r < 50) do_ack(q, 1'($urandom_range(0, 1)));
            else             do_req(q, 1'b0);
        end

        req_mode = 1;
        ack_mode = 1;
        wait_drain();
        repeat (4) tick();
        chk("final_req_outstanding", 128'(exp_req.size()), 128'(0));
        chk("final_ack_outstanding", 128'(exp_ack.size()), 128'(0));
        chk("final_uflow_outstanding", 128'(exp_uflow.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rdma_flow_ctrl.md
# rdma_flow_ctrl

Per-queue outstanding-request flow controller for the RDMA request path, sitting between the request arbiter and the RDMA stack. Tracks a sequence head and an outstanding count per queue (op-type, vFPGA, PID) in a single-port table. Admits a request only while its queue is below a runtime-programmable window, and stamps each request with its sequence number. Returns credits on ACKs and forwards last-ACKs. Adds table init sweep, per-queue flush and underflow reporting.

## Interface
Parameters:
- QID_BITS, 1+N_REGIONS_BITS+PID_BITS: queue-ID width; table depth 2^QID_BITS.
- N_OST, RDMA_N_WR_OUTSTANDING: max outstanding per queue; power of two, ≥2. OST_BITS = $clog2(N_OST).
- DATA_BITS, 128: opaque request payload width.
- ACK_BITS, 64: opaque ACK payload width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- cfg_limit  in  OST_BITS+1  window per queue; 0 blocks all requests; values >N_OST clamp to N_OST.
- init_done  out  1  table sweep complete.
- s_req_valid/s_req_ready  in/out  1  request handshake.
- s_req_qid  in  QID_BITS  request queue ID.
- s_req_data  in  DATA_BITS  request payload.
- m_req_valid/m_req_ready  out/in  1  admitted request.
- m_req_data  out  DATA_BITS  payload, unmodified.
- m_req_seq  out  OST_BITS  sequence number assigned.
- s_ack_valid/s_ack_ready  in/out  1  ACK handshake.
- s_ack_qid  in  QID_BITS  ACK queue ID.
- s_ack_last  in  1  forward this ACK.
- s_ack_data  in  ACK_BITS  ACK payload.
- m_ack_valid/m_ack_ready  out/in  1  forwarded ACK.
- m_ack_data  out  ACK_BITS  ACK payload.
- flush_valid/flush_ready  in/out  1  queue flush handshake.
- flush_qid  in  QID_BITS  queue to clear.
- err_uflow  out  1  one-cycle pulse: ACK on queue with count 0.
- err_qid  out  QID_BITS  queue of last underflow; holds until the next one.

## Operation
- Table entry: {head[OST_BITS-1:0], cnt[OST_BITS:0]}.
- Single FSM with states INIT, IDLE, LUP_WAIT, ACK_LUP, REQ_LUP and FLUSH; one operation in flight at a time, so there are no table hazards.
- INIT: writes zero to address 0..2^QID_BITS-1, one per cycle. Then goes to IDLE and sets init_done.
- IDLE priority is ACK > flush > request.
- ACK path:
  - Accepted in IDLE when the ACK queue is not full (s_ack_ready=1 that cycle).
  - If last, the ACK is pushed into the ACK queue in the same cycle.
  - Table read issued; next state LUP_WAIT, then ACK_LUP.
- ACK_LUP:
  - cnt>0: write cnt-1, head unchanged.
  - cnt==0: no write; pulse err_uflow and load err_qid. The ACK is still forwarded if last.
- Flush: flush_ready=1 in IDLE, then FLUSH writes zero to flush_qid. Outstanding ACKs arriving later for that queue raise underflow.
- Request path:
  - Lookup starts in IDLE when s_req_valid=1 and the request queue is not full; no handshake yet. Next state LUP_WAIT, then REQ_LUP.
  - REQ_LUP, when cnt < min(cfg_limit, N_OST): s_req_ready=1 and push {data, seq=head}; write head+1 (mod N_OST) and cnt+1.
  - Otherwise there is no handshake and the FSM returns to IDLE to retry; pending ACKs win the next IDLE.
- Every FSM path returns to IDLE; ACK_LUP, REQ_LUP and FLUSH all go to IDLE.
- Output queues: one req and one ACK queue, each depth N_OST.

## Timing
- Reset values:
  - state INIT, init_done=0, err_uflow=0, err_qid=0.
  - All s_*_ready=0, flush_ready=0, m_req_valid=0, m_ack_valid=0.
  - Queues emptied.
- A reset mid-operation aborts in-flight lookups and restarts INIT; no partial writes are retained.
- Init latency is 2^QID_BITS cycles after aresetn deasserts. Ready outputs stay low throughout.
- Request: lookup starts in IDLE at cycle t; handshake at t+2; m_req_valid earliest t+3.
- ACK: handshake at t; m_ack_valid earliest t+1; count write at t+2.
- Flush: handshake at t; write at t+1; the next operation can start at t+2.
- Throughput is one ACK or request per 3 cycles, one flush per 2 cycles.
- cfg_limit is sampled in REQ_LUP; a change applies from the next lookup. Lowering it below cnt never drops state.
- Table reads are registered (1-cycle RAM); LUP_WAIT covers the read latency.
- head wraps N_OST-1 → 0. cnt saturates by construction at N_OST.

## Structure
- Shared package lynxTypes holds:
  - the flow-table entry typedef;
  - RDMA_N_WR_OUTSTANDING;
  - the QID packing {is_rd, vfid, pid}, so callers build s_req_qid and s_ack_qid identically.
- Table is ram_sp_nc, ADDR_BITS=QID_BITS, DATA_BITS=2*OST_BITS+1.
- Output buffers are queue_meta, depth N_OST. A queue_meta variant with a full flag is the one natural sub-module.
- FSM, datapath and error logic stay inline.

## Test plan
Configuration: N_OST=4, QID_BITS=3.
- Reset release: init_done rises after 8 cycles. Table dump shows all entries zero. No ready asserted before init_done.
- cfg_limit=4: 5 requests on qid 2 → seq 0,1,2,3 emitted. The 5th stalls until one ACK on qid 2, then is emitted with seq 0 (wrap).
- cfg_limit=2, requests alternating qid 1 and 5 → each queue admits 2. Raising cfg_limit to 3 admits one more per queue.
- ACK on qid 3 with cnt=0, last=1 → err_uflow pulses once, err_qid=3, ACK forwarded, table entry stays zero.
- Simultaneous s_ack_valid, flush_valid and s_req_valid in IDLE → order of service is ACK, then flush, then request. After flush of qid 2, the next request on qid 2 gets seq 0.
- m_req_ready=0 while 4 requests are admitted → queue full, s_req_ready stays 0, no lookup starts. Releasing m_req_ready drains seq 0..3 in order.
